// File: rtl/div_seq.sv
// div_seq: iterative 32-bit restoring divider (div.w/mod.w/div.wu/mod.wu) for the EX stage
//   One quotient bit per cycle. Result is held in DONE until EX advances (ack).
//   Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the loop and finishes in one cycle.
//   Ports:
//     clk, reset   clock, synchronous active-high reset
//     req          divide request, held by EX until the instruction leaves
//     op           00 div.w, 01 mod.w, 10 div.wu, 11 mod.wu
//     src1, src2   dividend, divisor (sampled only on accept)
//     ack          EX advancing this cycle
//     flush        cancel any in-flight operation
//     busy         state is CALC or DONE
//     done         result valid (whole DONE state)
//     result       quotient or remainder per op
module div_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        ack,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);
  localparam int ITER = 32;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]  state;
  logic [1:0]  op_r;
  logic        sign_q, sign_r;
  logic [31:0] quo, dvs;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic        sgn;
  logic [31:0] abs1, abs2, quo_n, fin;
  logic [33:0] sh, trial;
  logic [32:0] rem_n;
  logic        fit;
  assign sgn   = ~op[1];
  assign abs1  = (sgn & src1[31]) ? -src1 : src1;
  assign abs2  = (sgn & src2[31]) ? -src2 : src2;
  // Borrow out of the trial subtraction means the shifted remainder is below the divisor.
  assign sh    = {rem, quo[31]};
  assign trial = sh - {2'b00, dvs};
  assign fit   = ~trial[33];
  assign rem_n = fit ? trial[32:0] : sh[32:0];
  assign quo_n = {quo[30:0], fit};
  assign fin   = op_r[0] ? (sign_r ? -rem_n[31:0] : rem_n[31:0])
                         : (sign_q ? -quo_n : quo_n);
  assign busy  = state != IDLE;
  assign done  = state == DONE;
`ifdef DIV_ZERO_FAST_EN
  logic [31:0] zres;
  assign zres = op[0] ? src1 : (sgn & src1[31]) ? 32'd1 : 32'hFFFF_FFFF;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op_r   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quo    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (req) begin
          op_r   <= op;
          quo    <= abs1;
          dvs    <= abs2;
          sign_q <= sgn & (src1[31] ^ src2[31]);
          sign_r <= sgn & src1[31];
          rem    <= '0;
          cnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
          if (src2 == 32'd0) begin
            result <= zres;
            state  <= DONE;
          end else begin
            state <= CALC;
          end
`else
          state  <= CALC;
`endif
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'(ITER - 1)) begin
            result <= fin;
            state  <= DONE;
          end
        end
        DONE: if (ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
